// File: rtl/pipe_sequencer_if.sv
// Pipeline sequencing bundle: mode/hazard inputs toward the sequencer, stage enables and perf counters back.
// master = pipeline datapath side, slave = sequencer side.
interface pipe_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             PAUSE;
   logic             STEP;
   logic [2:0]       IFID_RS;
   logic [2:0]       IFID_RT;
   logic             ID_USES_RS;
   logic             ID_USES_RT;
   logic             IDEX_MEMREAD;
   logic [2:0]       IDEX_WA;
   logic             WB_REGWRITE;
   logic             PC_EN;
   logic             IFID_EN;
   logic             IDEX_EN;
   logic             EXMEM_EN;
   logic             MEMWB_EN;
   logic             IDEX_BUBBLE;
   logic [1:0]       STATE;
   logic [CNT_W-1:0] CYCLE_CNT;
   logic [CNT_W-1:0] STALL_CNT;

   modport master (
      output PAUSE, STEP, IFID_RS, IFID_RT, ID_USES_RS, ID_USES_RT,
             IDEX_MEMREAD, IDEX_WA, WB_REGWRITE,
      input  PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN, IDEX_BUBBLE,
             STATE, CYCLE_CNT, STALL_CNT
   );

   modport slave (
      input  PAUSE, STEP, IFID_RS, IFID_RT, ID_USES_RS, ID_USES_RT,
             IDEX_MEMREAD, IDEX_WA, WB_REGWRITE,
      output PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, MEMWB_EN, IDEX_BUBBLE,
             STATE, CYCLE_CNT, STALL_CNT
   );
endinterface

// File: rtl/pipe_sequencer.sv
// Stage-enable/bubble generator for the 5-stage pipeline: warm-up, run/hold/single-step, load-use and RF-port stalls.
// Enables are combinational from registered mode plus same-cycle hazards; no backpressure beyond the enables themselves.
module pipe_sequencer #(
   parameter int WARMUP_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input logic             CLK,
   input logic             RST_N,
   pipe_sequencer_if.slave io
);
   localparam logic [1:0] S_WARMUP = 2'b00;
   localparam logic [1:0] S_RUN    = 2'b01;
   localparam logic [1:0] S_HOLD   = 2'b10;
   localparam logic [1:0] S_STEP1  = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state_q, state_d;
   logic [3:0]       warm_q, warm_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             advance, load_use, port_conflict, stall;

   always_comb begin
      advance       = (state_q == S_RUN) || (state_q == S_STEP1);
      load_use      = io.IDEX_MEMREAD &
                      ((io.ID_USES_RS & (io.IDEX_WA == io.IFID_RS)) |
                       (io.ID_USES_RT & (io.IDEX_WA == io.IFID_RT)));
      // RF port A is shared between the WB write and the ID read of RS
      port_conflict = io.WB_REGWRITE & io.ID_USES_RS;
      stall         = advance & (load_use | port_conflict);
   end

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      case (state_q)
         S_WARMUP: begin
            warm_d = warm_q - 4'd1;
            if (warm_q == 4'd1) begin
               state_d = io.PAUSE ? S_HOLD : S_RUN;
            end
         end
         S_RUN: begin
            if (io.PAUSE) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (io.STEP) begin
               state_d = S_STEP1;
            end else if (!io.PAUSE) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = io.PAUSE ? S_HOLD : S_RUN;
         end
      endcase
   end

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (advance && (cycle_cnt_q != CNT_MAX)) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_WARMUP;
         warm_q      <= 4'(WARMUP_CYCLES);
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         cycle_cnt_q <= cycle_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      io.IDEX_EN     = advance;
      io.EXMEM_EN    = advance;
      io.MEMWB_EN    = advance;
      io.PC_EN       = advance & ~stall;
      io.IFID_EN     = advance & ~stall;
      io.IDEX_BUBBLE = stall;
      io.STATE       = state_q;
      io.CYCLE_CNT   = cycle_cnt_q;
      io.STALL_CNT   = stall_cnt_q;
   end
endmodule
